// File: rtl/l1_cache.sv
// Direct-mapped write-back/write-allocate L1 with 16-bit CPU port and 128-bit line memory port.
// Hits respond combinationally in IDLE; misses hold the CPU until pmem_resp completes writeback/fill.
module l1_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_wmask,
  input  logic [15:0]  mem_address,
  input  logic [15:0]  mem_wdata,
  output logic         mem_resp,
  output logic [15:0]  mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int TAG_W = 12 - S_INDEX;
  localparam int SETS  = 1 << S_INDEX;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state_q, state_d;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [127:0]     data_q [SETS];
  logic [11:0]      miss_line_q;

  logic [S_INDEX-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0]   req_tag, miss_tag;
  logic [2:0]         word_sel;
  logic               req, hit, victim_dirty;
  logic               wr_hit, miss_start, wb_done, fill_done;
  logic               unused_addr_bit;

  assign req_idx         = mem_address[4 +: S_INDEX];
  assign req_tag         = mem_address[15 -: TAG_W];
  assign word_sel        = mem_address[3:1];
  assign miss_idx        = miss_line_q[S_INDEX-1:0];
  assign miss_tag        = miss_line_q[11 -: TAG_W];
  assign unused_addr_bit = mem_address[0];

  assign req          = mem_read | mem_write;
  assign hit          = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign victim_dirty = valid_q[req_idx] && dirty_q[req_idx];

  assign mem_rdata  = data_q[req_idx][{word_sel, 4'h0} +: 16];
  assign pmem_wdata = data_q[miss_idx];

  always_comb begin
    state_d      = state_q;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    wr_hit       = 1'b0;
    miss_start   = 1'b0;
    wb_done      = 1'b0;
    fill_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp = 1'b1;
            // read+write together is a write
            wr_hit   = mem_write;
          end else begin
            miss_start = 1'b1;
            state_d    = victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[miss_idx], miss_idx, 4'h0};
        if (pmem_resp) begin
          wb_done = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_line_q, 4'h0};
        if (pmem_resp) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset wins: no response, no array update, late pmem_resp ignored
    if (reset) begin
      state_d    = IDLE;
      mem_resp   = 1'b0;
      wr_hit     = 1'b0;
      miss_start = 1'b0;
      wb_done    = 1'b0;
      fill_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_line_q <= '0;
    end else begin
      state_q <= state_d;
      // Latch the miss line so a withdrawn/changed request cannot corrupt the fill
      if (miss_start) miss_line_q <= mem_address[15:4];
      if (wr_hit && (mem_wmask != 2'b00)) dirty_q[req_idx] <= 1'b1;
      if (wb_done) dirty_q[miss_idx] <= 1'b0;
      if (fill_done) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      if (mem_wmask[0]) data_q[req_idx][{word_sel, 4'h0} +: 8] <= mem_wdata[7:0];
      if (mem_wmask[1]) data_q[req_idx][{word_sel, 4'h8} +: 8] <= mem_wdata[15:8];
    end
    if (fill_done) begin
      data_q[miss_idx] <= pmem_rdata;
      tag_q[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Scoreboard bench for l1_cache: flat-memory reference model predicts read data and line traffic.
// A responder plays physical memory with random latency; a monitor checks every CPU response.
module tb_l1_cache;

  localparam int S_INDEX = 3;
  localparam int SETS    = 1 << S_INDEX;

  logic         clk = 1'b0;
  logic         reset;
  logic         mem_read, mem_write;
  logic [1:0]   mem_wmask;
  logic [15:0]  mem_address, mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  l1_cache #(.S_INDEX(S_INDEX)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; bit hit; logic [15:0] rdata; int cyc; } resp_t;
  typedef struct { bit wr; logic [15:0] addr; logic [127:0] wdata; } pop_t;

  resp_t exp_q[$];
  pop_t  pexp_q[$];

  // CPU-visible memory, physical memory, and which line each set holds
  logic [127:0] ref_mem  [int];
  logic [127:0] phys_mem [int];
  bit m_valid [SETS];
  bit m_dirty [SETS];
  int m_line  [SETS];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit hold_resp = 1'b0;
  bit stray_req = 1'b0;

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function automatic void touch(input int la);
    logic [127:0] v;
    if (!ref_mem.exists(la)) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      ref_mem[la]  = v;
      phys_mem[la] = v;
    end
  endfunction

  function automatic void predict(input bit wr, input logic [15:0] a, input logic [1:0] m,
                                  input logic [15:0] d, output resp_t e);
    int la, set, w;
    pop_t p;
    logic [127:0] line;
    la  = int'(a[15:4]);
    set = la % SETS;
    w   = int'(a[3:1]);
    touch(la);
    e.hit = m_valid[set] && (m_line[set] == la);
    if (!e.hit) begin
      if (m_valid[set] && m_dirty[set]) begin
        p.wr = 1'b1; p.addr = 16'(m_line[set] << 4); p.wdata = ref_mem[m_line[set]];
        pexp_q.push_back(p);
      end
      p.wr = 1'b0; p.addr = 16'(la << 4); p.wdata = '0;
      pexp_q.push_back(p);
      m_valid[set] = 1'b1; m_line[set] = la; m_dirty[set] = 1'b0;
    end
    line    = ref_mem[la];
    e.wr    = wr;
    e.rdata = line[w*16 +: 16];
    e.cyc   = 0;
    if (wr) begin
      if (m[0]) line[w*16 +: 8]     = d[7:0];
      if (m[1]) line[w*16 + 8 +: 8] = d[15:8];
      ref_mem[la] = line;
      if (m != 2'b00) m_dirty[set] = 1'b1;
    end
  endfunction

  task automatic finish_now();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  endtask

  // Called at posedge+1; returns at posedge+1 after the response cycle
  task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                        input logic [1:0] m, input logic [15:0] d);
    resp_t e;
    int t;
    predict(wr, a, m, d, e);
    mem_read = rd; mem_write = wr; mem_address = a; mem_wmask = m; mem_wdata = d;
    e.cyc = cyc;
    exp_q.push_back(e);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mem_resp && t < 300);
    if (!mem_resp) begin
      fail("resp_timeout");
      finish_now();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    mem_read = 1'b0; mem_write = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_valid[s] = 1'b0; m_dirty[s] = 1'b0; m_line[s] = 0;
    end
    ref_mem = phys_mem;
    exp_q.delete();
    pexp_q.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (mem_resp) begin
        if (exp_q.size() == 0) fail("unexpected_mem_resp");
        else begin
          e = exp_q.pop_front();
          if (!e.wr) check("mem_rdata", mem_rdata, e.rdata);
          check("hit_same_cycle", cyc == e.cyc, e.hit);
        end
        check("resp_during_pmem", pmem_read | pmem_write, 1'b0);
      end
    end
  end

  // Physical memory responder
  initial begin
    bit active;
    int wcnt, cur_la;
    bit cur_write;
    logic [127:0] cur_wdata;
    pop_t p;
    active = 1'b0; wcnt = 0; cur_la = 0; cur_write = 1'b0; cur_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (reset) begin
        active = 1'b0;
        continue;
      end
      if (stray_req) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        continue;
      end
      if (pmem_read || pmem_write) check("pmem_excl", pmem_read & pmem_write, 1'b0);
      if (!active && (pmem_read || pmem_write)) begin
        active = 1'b1;
        wcnt   = $urandom_range(0, 3);
        if (pexp_q.size() == 0) fail("unexpected_pmem_op");
        else begin
          p = pexp_q.pop_front();
          check("pmem_op_is_write", pmem_write, p.wr);
          check("pmem_address", pmem_address, p.addr);
          if (p.wr) check("pmem_wdata", pmem_wdata, p.wdata);
        end
        cur_write = pmem_write;
        cur_la    = int'(pmem_address[15:4]);
        cur_wdata = pmem_wdata;
      end
      if (active && !hold_resp) begin
        if (wcnt == 0) begin
          pmem_resp = 1'b1;
          if (cur_write) phys_mem[cur_la] = cur_wdata;
          else if (phys_mem.exists(cur_la)) pmem_rdata = phys_mem[cur_la];
          else pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
          active = 1'b0;
        end else begin
          wcnt--;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    fail("global_timeout");
    finish_now();
  end

  initial begin
    logic [127:0] line;
    int t;
    resp_t e;
    reset = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    mem_wmask = 2'b00; mem_address = '0; mem_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_mem_resp", mem_resp, 1'b0);
    check("reset_pmem_read", pmem_read, 1'b0);
    check("reset_pmem_write", pmem_write, 1'b0);
    @(posedge clk);
    #1;

    // Cold read with word 2 of line 0x123 = BEEF
    touch(12'h123);
    line = ref_mem[12'h123];
    line[47:32] = 16'hBEEF;
    ref_mem[12'h123]  = line;
    phys_mem[12'h123] = line;
    do_req(1, 0, 16'h1234, 2'b00, 16'h0000);
    do_req(1, 0, 16'h1230, 2'b00, 16'h0000);
    do_req(0, 1, 16'h1234, 2'b01, 16'h00AA);
    do_req(1, 0, 16'h1234, 2'b00, 16'h0000);
    do_req(1, 0, 16'h5234, 2'b00, 16'h0000);
    idle(2);

    // wmask=00 on a clean hit leaves it clean: the conflict miss must not write back
    do_req(1, 0, 16'h2234, 2'b00, 16'h0000);
    do_req(0, 1, 16'h2234, 2'b00, 16'hFFFF);
    do_req(1, 0, 16'h2234, 2'b00, 16'h0000);
    do_req(1, 0, 16'h6234, 2'b00, 16'h0000);
    idle(2);

    // Reset while a fill is outstanding
    hold_resp = 1'b1;
    predict(1'b0, 16'h1234, 2'b00, 16'h0000, e);
    mem_read = 1'b1; mem_address = 16'h1234;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!pmem_read && t < 50);
    check("alloc_seen", pmem_read, 1'b1);
    check("alloc_addr", pmem_address, 16'h1230);
    reset = 1'b1;
    @(negedge clk);
    check("rst_alloc_pmem_read", pmem_read, 1'b0);
    check("rst_alloc_mem_resp", mem_resp, 1'b0);
    reset = 1'b0; mem_read = 1'b0;
    model_reset();
    hold_resp = 1'b0;
    @(posedge clk);
    #1;

    // Stray pmem_resp while idle must be ignored; 0x1234 then misses again
    stray_req = 1'b1;
    @(negedge clk);
    #1 stray_req = 1'b0;
    @(posedge clk);
    #1;
    do_req(1, 0, 16'h1234, 2'b00, 16'h0000);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      int k;
      a = 16'(($urandom_range(0, 3) << 13) | ($urandom_range(0, SETS - 1) << 4) | $urandom_range(0, 15));
      k = $urandom_range(0, 9);
      if (k < 5)      do_req(1, 0, a, 2'b00, 16'h0000);
      else if (k < 9) do_req(0, 1, a, 2'($urandom_range(0, 3)), 16'($urandom));
      else            do_req(1, 1, a, 2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 7) == 0) idle(1);
    end

    idle(5);
    check("resp_queue_drained", exp_q.size(), 0);
    check("pmem_queue_drained", pexp_q.size(), 0);
    finish_now();
  end

endmodule
